aib_avmm_cfg_arbiter: RTL and testbench
=======================================

# aib_avmm_cfg_arbiter

Shares the single Avalon-MM configuration port of the AIB-AXI bridge between two requesters: the calibration master FSM (requester 0) and an external host/debug master (requester 1). The calibration FSM has fixed priority until calibration completes; after that, the two requesters alternate round-robin. The block registers and issues one transaction at a time to the bridge. It steers read data back to the requester that issued the read and times out reads that never return.

## Interface
- AVMM_WIDTH, 32, data width
- BYTE_WIDTH, 4, byte-enable width (AVMM_WIDTH/8)
- ADDR_WIDTH, 17, address width
- RD_TIMEOUT, 255, cycles to wait for readdatavalid before forcing completion (1..255)

Ports:
- i_cfg_avmm_clk  in  1  single clock for the whole block
- i_cfg_avmm_rst_n  in  1  asynchronous active-low reset
- calib_done  in  1  high selects round-robin; low gives requester 0 fixed priority
- rq_addr[r]/rq_byte_en[r]/rq_read[r]/rq_write[r]/rq_wdata[r]  in  ADDR_WIDTH/BYTE_WIDTH/1/1/AVMM_WIDTH  per-requester command, r∈{0,1}; flattened as rq0_*, rq1_*
- rq_waitreq[r]  out  1  per-requester waitrequest
- rq_rdata[r]  out  AVMM_WIDTH  per-requester read data
- rq_rdatavld[r]  out  1  per-requester read data valid
- o_cfg_avmm_addr/byte_en/read/write/wdata  out  ADDR_WIDTH/BYTE_WIDTH/1/1/AVMM_WIDTH  command to bridge
- i_cfg_avmm_rdata  in  AVMM_WIDTH  bridge read data
- i_cfg_avmm_rdatavld  in  1  bridge read data valid
- i_cfg_avmm_waitreq  in  1  bridge waitrequest
- grant  out  1  index of the current or last granted requester
- busy  out  1  high when the FSM is not in IDLE
- rd_timeout_err  out  1  one-cycle pulse when a read times out

## Operation
- **FSM states:** IDLE, CMD, RD_WAIT.
- **IDLE, requester selection:** a requester is requesting when rq_read or rq_write is high.
  - If only one requester is requesting, it wins.
  - If both are requesting and calib_done=0, requester 0 wins.
  - If both are requesting and calib_done=1, the requester that is not the last grantee wins.
- **IDLE, acceptance:** the winner's rq_waitreq goes low combinationally in that cycle. The command is latched, grant is updated, and the FSM moves to CMD.
- **Both read and write high:** the write is taken and the read is ignored.
- **CMD:** the latched command drives the o_cfg_avmm_* outputs.
  - The command holds while i_cfg_avmm_waitreq=1.
  - When waitreq=0 is sampled, read/write deassert the next cycle.
  - After a write, the FSM returns to IDLE.
  - After a read, the FSM goes to RD_WAIT and the timeout counter is cleared.
- **RD_WAIT, normal completion:** on i_cfg_avmm_rdatavld=1, rq_rdata[grant] is registered and rq_rdatavld[grant] pulses for one cycle. The FSM returns to IDLE.
- **RD_WAIT, timeout:** when the counter reaches RD_TIMEOUT, rq_rdatavld[grant] pulses with rq_rdata={AVMM_WIDTH{1'b0}}, rd_timeout_err pulses, and the FSM returns to IDLE.
- **Stray readdatavalid:** i_cfg_avmm_rdatavld seen in IDLE or CMD is dropped.
- **Non-selected requesters:** rq_waitreq stays high in every state except the acceptance cycle.
- **Timeout counter:** 8 bits, saturating, reset to 0 on entry to RD_WAIT.

## Timing
- **Reset values:**
  - o_cfg_avmm_read/write = 0; addr, byte_en, wdata = 0.
  - rq_waitreq = 1 for both requesters.
  - rq_rdatavld = 0; rq_rdata = 0.
  - grant = 1, so the first contention after calib_done goes to requester 0.
  - busy = 0; rd_timeout_err = 0; state = IDLE.
- **Issue latency:** a command accepted in cycle N appears on o_cfg_avmm_* in cycle N+1.
- **Write:** with zero downstream wait, it completes in N+1. The next acceptance is possible in N+2.
- **Read:** with bridge readdatavalid in cycle M, the requester sees rq_rdatavld in M+1.
- **Throughput:** at most one outstanding transaction.
- **Reset mid-transaction:** an asserted reset aborts immediately. All outputs take reset values, with no rdatavld to either requester.
- **calib_done changes:** a change takes effect only at the next IDLE decision and never preempts a transaction in progress.

## Structure
- **Shared package aib_cfg_pkg:** state enum (IDLE/CMD/RD_WAIT), the requester count constant (2), and the default RD_TIMEOUT.
- **Sub-module:** one natural sub-module, aib_cfg_rr_pick (two-way fixed/round-robin priority pick, combinational, inputs req[1:0], last, fixed_prio).

## Test plan
- **Write from requester 0:** rq0 write addr 0x00208, data 0x0000_0003, bridge waitreq 0 → o_cfg_avmm_write high exactly one cycle (N+1) with the same addr/data; rq0_waitreq low only in cycle N.
- **Contention, calib_done=0:** both requesters write simultaneously → rq0 is served first, then rq1. Issue order 0,1; grant sequence 0,1.
- **Contention, calib_done=1:** both requesters continuously request 4 writes each → issue order alternates 0,1,0,1,...
- **Read with stalls:** rq1 reads addr 0x00300; bridge holds waitreq 3 cycles, then returns rdata 0xA5A5_1234 after 5 cycles → rq1_rdatavld one pulse with 0xA5A5_1234; rq0_rdatavld stays 0.
- **Read timeout:** read with no rdatavld → after 255 cycles in RD_WAIT, rq0_rdatavld pulses with 0 and rd_timeout_err pulses once. A subsequent late rdatavld is dropped.
- **Reset during CMD:** assert rst_n low while the bridge waitreq=1 → all outputs return to reset values asynchronously; after release, a new write completes normally.

Source files
------------

// File: rtl/aib_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aib_cfg_pkg
// Description : Shared types and constants for the AIB configuration-port
//               arbiter (FSM states, requester count, default read timeout).
// Revision    : 1.0 - initial release
// ============================================================================
package aib_cfg_pkg;

    // Number of requesters sharing the configuration port
    localparam int c_num_req = 2;

    // Default number of RD_WAIT cycles before a read is forced to complete
    localparam int c_rd_timeout_dflt = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_RD_WAIT = 2'd2
    } cfg_state_e;

endpackage : aib_cfg_pkg
`default_nettype wire

// File: rtl/aib_cfg_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : aib_cfg_rr_pick
// Description : Two-way requester pick. A lone requester always wins; on
//               contention requester 0 wins under fixed priority, otherwise
//               the requester that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module aib_cfg_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       vld,
    output logic       win
);

    // Pure combinational winner selection
    always_comb begin
        vld = |req;
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = fixed_prio ? 1'b0 : ~last;
            default: win = 1'b0;
        endcase
    end

endmodule : aib_cfg_rr_pick
`default_nettype wire

// File: rtl/aib_avmm_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aib_avmm_cfg_arbiter
// Description : Shares the bridge Avalon-MM configuration port between the
//               calibration FSM (requester 0) and a host/debug master
//               (requester 1). One transaction in flight, read data steered
//               back to the issuer, reads that never return are timed out.
// Revision    : 1.0 - initial release
// ============================================================================
module aib_avmm_cfg_arbiter
    import aib_cfg_pkg::*;
#(
    parameter int AVMM_WIDTH = 32,
    parameter int BYTE_WIDTH = 4,
    parameter int ADDR_WIDTH = 17,
    parameter int RD_TIMEOUT = c_rd_timeout_dflt
) (
    input  logic                  i_cfg_avmm_clk,
    input  logic                  i_cfg_avmm_rst_n,
    input  logic                  calib_done,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [BYTE_WIDTH-1:0] rq0_byte_en,
    input  logic                  rq0_read,
    input  logic                  rq0_write,
    input  logic [AVMM_WIDTH-1:0] rq0_wdata,
    output logic                  rq0_waitreq,
    output logic [AVMM_WIDTH-1:0] rq0_rdata,
    output logic                  rq0_rdatavld,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [BYTE_WIDTH-1:0] rq1_byte_en,
    input  logic                  rq1_read,
    input  logic                  rq1_write,
    input  logic [AVMM_WIDTH-1:0] rq1_wdata,
    output logic                  rq1_waitreq,
    output logic [AVMM_WIDTH-1:0] rq1_rdata,
    output logic                  rq1_rdatavld,
    output logic [ADDR_WIDTH-1:0] o_cfg_avmm_addr,
    output logic [BYTE_WIDTH-1:0] o_cfg_avmm_byte_en,
    output logic                  o_cfg_avmm_read,
    output logic                  o_cfg_avmm_write,
    output logic [AVMM_WIDTH-1:0] o_cfg_avmm_wdata,
    input  logic [AVMM_WIDTH-1:0] i_cfg_avmm_rdata,
    input  logic                  i_cfg_avmm_rdatavld,
    input  logic                  i_cfg_avmm_waitreq,
    output logic                  grant,
    output logic                  busy,
    output logic                  rd_timeout_err
);

    localparam logic [7:0] c_tmo_lim = 8'(RD_TIMEOUT);

    // Requester commands gathered into arrays indexed by requester number
    logic [ADDR_WIDTH-1:0] w_rq_addr  [c_num_req];
    logic [BYTE_WIDTH-1:0] w_rq_be    [c_num_req];
    logic [AVMM_WIDTH-1:0] w_rq_wdata [c_num_req];
    logic [c_num_req-1:0]  w_rq_rd;
    logic [c_num_req-1:0]  w_rq_wr;
    logic [c_num_req-1:0]  w_req;
    logic [c_num_req-1:0]  w_waitreq;
    logic                  w_pick_vld;
    logic                  w_pick_win;
    logic                  w_fixed_prio;

    cfg_state_e            state_q,    state_d;
    logic                  grant_q,    grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [BYTE_WIDTH-1:0] be_q,       be_d;
    logic [AVMM_WIDTH-1:0] wdata_q,    wdata_d;
    logic                  read_q,     read_d;
    logic                  write_q,    write_d;
    logic [7:0]            cnt_q,      cnt_d;
    logic [AVMM_WIDTH-1:0] rdata_q    [c_num_req];
    logic [AVMM_WIDTH-1:0] rdata_d    [c_num_req];
    logic [c_num_req-1:0]  rdatavld_q, rdatavld_d;
    logic                  tmo_err_q,  tmo_err_d;

    assign w_rq_addr[0]  = rq0_addr;
    assign w_rq_addr[1]  = rq1_addr;
    assign w_rq_be[0]    = rq0_byte_en;
    assign w_rq_be[1]    = rq1_byte_en;
    assign w_rq_wdata[0] = rq0_wdata;
    assign w_rq_wdata[1] = rq1_wdata;
    assign w_rq_rd       = {rq1_read, rq0_read};
    assign w_rq_wr       = {rq1_write, rq0_write};
    assign w_req         = w_rq_rd | w_rq_wr;
    assign w_fixed_prio  = ~calib_done;

    aib_cfg_rr_pick u_pick (
        .req        (w_req),
        .last       (grant_q),
        .fixed_prio (w_fixed_prio),
        .vld        (w_pick_vld),
        .win        (w_pick_win)
    );

    // Next-state, command capture and read-return steering
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        read_d     = read_q;
        write_d    = write_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rdatavld_d = '0;
        tmo_err_d  = 1'b0;
        w_waitreq  = '1;
        case (state_q)
            ST_IDLE: begin
                // Acceptance is masked while reset is held so waitrequest
                // reads as its reset value even with a request pending.
                if (w_pick_vld && i_cfg_avmm_rst_n) begin
                    w_waitreq[w_pick_win] = 1'b0;
                    grant_d = w_pick_win;
                    addr_d  = w_rq_addr[w_pick_win];
                    be_d    = w_rq_be[w_pick_win];
                    wdata_d = w_rq_wdata[w_pick_win];
                    // A write wins over a simultaneous read
                    write_d = w_rq_wr[w_pick_win];
                    read_d  = w_rq_rd[w_pick_win] & ~w_rq_wr[w_pick_win];
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!i_cfg_avmm_waitreq) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (read_q) begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_WAIT: begin
                // Counter holds the number of RD_WAIT cycles already spent
                if (i_cfg_avmm_rdatavld) begin
                    rdata_d[grant_q]    = i_cfg_avmm_rdata;
                    rdatavld_d[grant_q] = 1'b1;
                    state_d             = ST_IDLE;
                end else if (cnt_q == c_tmo_lim) begin
                    rdata_d[grant_q]    = '0;
                    rdatavld_d[grant_q] = 1'b1;
                    tmo_err_d           = 1'b1;
                    state_d             = ST_IDLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b1;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < c_num_req; i++) begin
                rdata_q[i] <= '0;
            end
            rdatavld_q <= '0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            read_q     <= read_d;
            write_q    <= write_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rdatavld_q <= rdatavld_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign rq0_waitreq        = w_waitreq[0];
    assign rq1_waitreq        = w_waitreq[1];
    assign rq0_rdata          = rdata_q[0];
    assign rq1_rdata          = rdata_q[1];
    assign rq0_rdatavld       = rdatavld_q[0];
    assign rq1_rdatavld       = rdatavld_q[1];
    assign o_cfg_avmm_addr    = addr_q;
    assign o_cfg_avmm_byte_en = be_q;
    assign o_cfg_avmm_read    = read_q;
    assign o_cfg_avmm_write   = write_q;
    assign o_cfg_avmm_wdata   = wdata_q;
    assign grant              = grant_q;
    assign busy               = (state_q != ST_IDLE);
    assign rd_timeout_err     = tmo_err_q;

endmodule : aib_avmm_cfg_arbiter
`default_nettype wire

// File: tb/tb_aib_avmm_cfg_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_aib_avmm_cfg_arbiter
// Description : Self-checking bench: requester queues, a bridge responder and
//               a transaction-level reference for arbitration and read return.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aib_avmm_cfg_arbiter;

    localparam int AW  = 32;
    localparam int BW  = 4;
    localparam int ADW = 17;
    localparam int TMO = 255;

    typedef struct {
        logic           rd;
        logic           wr;
        logic [ADW-1:0] addr;
        logic [BW-1:0]  be;
        logic [AW-1:0]  data;
    } cmd_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           calib_done = 1'b0;
    logic [ADW-1:0] rq_addr  [2];
    logic [BW-1:0]  rq_be    [2];
    logic [AW-1:0]  rq_wdata [2];
    logic [1:0]     rq_read  = '0;
    logic [1:0]     rq_write = '0;
    logic           rq0_waitreq, rq1_waitreq, rq0_rdatavld, rq1_rdatavld;
    logic [AW-1:0]  rq0_rdata, rq1_rdata;
    logic [ADW-1:0] o_cfg_avmm_addr;
    logic [BW-1:0]  o_cfg_avmm_byte_en;
    logic           o_cfg_avmm_read, o_cfg_avmm_write;
    logic [AW-1:0]  o_cfg_avmm_wdata;
    logic [AW-1:0]  br_rdata = '0;
    logic           br_rdatavld = 1'b0;
    logic           br_waitreq = 1'b1;
    logic           grant, busy, rd_timeout_err;

    aib_avmm_cfg_arbiter dut (
        .i_cfg_avmm_clk      (clk),
        .i_cfg_avmm_rst_n    (rst_n),
        .calib_done          (calib_done),
        .rq0_addr            (rq_addr[0]),
        .rq0_byte_en         (rq_be[0]),
        .rq0_read            (rq_read[0]),
        .rq0_write           (rq_write[0]),
        .rq0_wdata           (rq_wdata[0]),
        .rq0_waitreq         (rq0_waitreq),
        .rq0_rdata           (rq0_rdata),
        .rq0_rdatavld        (rq0_rdatavld),
        .rq1_addr            (rq_addr[1]),
        .rq1_byte_en         (rq_be[1]),
        .rq1_read            (rq_read[1]),
        .rq1_write           (rq_write[1]),
        .rq1_wdata           (rq_wdata[1]),
        .rq1_waitreq         (rq1_waitreq),
        .rq1_rdata           (rq1_rdata),
        .rq1_rdatavld        (rq1_rdatavld),
        .o_cfg_avmm_addr     (o_cfg_avmm_addr),
        .o_cfg_avmm_byte_en  (o_cfg_avmm_byte_en),
        .o_cfg_avmm_read     (o_cfg_avmm_read),
        .o_cfg_avmm_write    (o_cfg_avmm_write),
        .o_cfg_avmm_wdata    (o_cfg_avmm_wdata),
        .i_cfg_avmm_rdata    (br_rdata),
        .i_cfg_avmm_rdatavld (br_rdatavld),
        .i_cfg_avmm_waitreq  (br_waitreq),
        .grant               (grant),
        .busy                (busy),
        .rd_timeout_err      (rd_timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side pending commands and the command currently presented
    cmd_t       fifo0[$];
    cmd_t       fifo1[$];
    cmd_t       pres_cmd [2];
    logic [1:0] pres = '0;

    // Reference: 0 = nothing in flight, 1 = command on the bus, 2 = awaiting read data
    int         phase = 0;
    cmd_t       cur;
    int         cur_rq = 0;
    int         m_last = 1;
    int         cmd_cyc = 0;
    int         wait_cyc = 0;
    int         stall_n = 0;
    int         dly_n = 0;
    bit         noresp = 1'b0;
    logic [1:0] exp_vld = '0;
    logic [AW-1:0] exp_data = '0;
    logic       exp_err = 1'b0;
    int         order[$];

    // Bridge / stimulus configuration
    bit            br_rand = 1'b0;
    int            br_stall = 0;
    int            br_dly = 0;
    logic [AW-1:0] br_data = '0;
    bit            br_noresp = 1'b0;
    int            stray_pct = 0;
    int            gap_pct = 0;
    bit            calib_rand = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic pop_rq(input int r, output cmd_t c);
        if (r == 0) c = fifo0.pop_front();
        else        c = fifo1.pop_front();
    endtask

    function automatic int fifo_size(input int r);
        return (r == 0) ? fifo0.size() : fifo1.size();
    endfunction

    function automatic cmd_t mk(input logic rd, input logic wr, input logic [ADW-1:0] a,
                                input logic [BW-1:0] be, input logic [AW-1:0] d);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.be = be; c.data = d;
        return c;
    endfunction

    // Drive requester and bridge inputs for the coming cycle
    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            if (!pres[r] && fifo_size(r) > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
                pop_rq(r, pres_cmd[r]);
                pres[r] = 1'b1;
            end
            if (pres[r]) begin
                rq_read[r]  = pres_cmd[r].rd;
                rq_write[r] = pres_cmd[r].wr;
                rq_addr[r]  = pres_cmd[r].addr;
                rq_be[r]    = pres_cmd[r].be;
                rq_wdata[r] = pres_cmd[r].data;
            end else begin
                rq_read[r]  = 1'b0;
                rq_write[r] = 1'b0;
                rq_addr[r]  = ADW'($urandom);
                rq_be[r]    = BW'($urandom);
                rq_wdata[r] = $urandom;
            end
        end
        if (calib_rand && $urandom_range(0, 9) == 0) calib_done = ~calib_done;
        br_waitreq  = (phase == 1) ? (cmd_cyc < stall_n) : 1'($urandom_range(0, 1));
        br_rdatavld = 1'b0;
        br_rdata    = $urandom;
        if (phase == 2) begin
            if (!noresp && wait_cyc == dly_n) begin
                br_rdatavld = 1'b1;
                if (!br_rand) br_rdata = br_data;
            end
        end else if (int'($urandom_range(0, 99)) < stray_pct) begin
            br_rdatavld = 1'b1;
        end
    endtask

    // Compare DUT outputs with the reference, then advance the reference
    task automatic sample();
        logic [1:0] exp_wreq;
        int         win;
        exp_wreq = 2'b11;
        check("busy", busy, phase != 0);
        check("grant", grant, m_last);
        check("rdvld0", rq0_rdatavld, exp_vld[0]);
        check("rdvld1", rq1_rdatavld, exp_vld[1]);
        if (exp_vld[0]) check("rdata0", rq0_rdata, exp_data);
        if (exp_vld[1]) check("rdata1", rq1_rdata, exp_data);
        check("tmo_err", rd_timeout_err, exp_err);
        if (phase == 1) begin
            check("bus_wr", o_cfg_avmm_write, cur.wr);
            check("bus_rd", o_cfg_avmm_read, cur.rd & ~cur.wr);
            check("bus_addr", o_cfg_avmm_addr, cur.addr);
            check("bus_be", o_cfg_avmm_byte_en, cur.be);
            if (cur.wr) check("bus_wdata", o_cfg_avmm_wdata, cur.data);
        end else begin
            check("bus_wr_quiet", o_cfg_avmm_write, 0);
            check("bus_rd_quiet", o_cfg_avmm_read, 0);
        end
        exp_vld = '0;
        exp_err = 1'b0;
        case (phase)
            0: if (pres != 2'b00) begin
                if (pres == 2'b01)      win = 0;
                else if (pres == 2'b10) win = 1;
                else                    win = calib_done ? 1 - m_last : 0;
                exp_wreq[win] = 1'b0;
                cur     = pres_cmd[win];
                cur_rq  = win;
                pres[win] = 1'b0;
                m_last  = win;
                phase   = 1;
                cmd_cyc = 0;
                if (br_rand) begin
                    stall_n = int'($urandom_range(0, 3));
                    dly_n   = int'($urandom_range(0, 6));
                    noresp  = ($urandom_range(0, 49) == 0);
                end else begin
                    stall_n = br_stall;
                    dly_n   = br_dly;
                    noresp  = br_noresp;
                end
            end
            1: if (!br_waitreq) begin
                order.push_back(int'(o_cfg_avmm_addr[16]));
                phase    = cur.wr ? 0 : 2;
                wait_cyc = 0;
            end else begin
                cmd_cyc++;
            end
            2: if (br_rdatavld) begin
                exp_vld[cur_rq] = 1'b1;
                exp_data = br_rdata;
                phase    = 0;
            end else if (wait_cyc == TMO) begin
                exp_vld[cur_rq] = 1'b1;
                exp_data = '0;
                exp_err  = 1'b1;
                phase    = 0;
            end else begin
                wait_cyc++;
            end
            default: phase = 0;
        endcase
        check("waitreq0", rq0_waitreq, exp_wreq[0]);
        check("waitreq1", rq1_waitreq, exp_wreq[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        bit pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < budget) begin
            cycle();
            n++;
            pending = (fifo0.size() + fifo1.size() != 0) || (pres != 2'b00) ||
                      (phase != 0) || (exp_vld != 2'b00);
        end
        check({tag, "_drain"}, pending, 0);
    endtask

    task automatic check_order(input string tag, input int exp_q[$]);
        check({tag, "_len"}, order.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < order.size(); i++) check(tag, order[i], exp_q[i]);
    endtask

    task automatic check_reset(input string t);
        check({t, "_wr"}, o_cfg_avmm_write, 0);
        check({t, "_rd"}, o_cfg_avmm_read, 0);
        check({t, "_addr"}, o_cfg_avmm_addr, 0);
        check({t, "_be"}, o_cfg_avmm_byte_en, 0);
        check({t, "_wdata"}, o_cfg_avmm_wdata, 0);
        check({t, "_wreq0"}, rq0_waitreq, 1);
        check({t, "_wreq1"}, rq1_waitreq, 1);
        check({t, "_vld0"}, rq0_rdatavld, 0);
        check({t, "_vld1"}, rq1_rdatavld, 0);
        check({t, "_rdata0"}, rq0_rdata, 0);
        check({t, "_rdata1"}, rq1_rdata, 0);
        check({t, "_grant"}, grant, 1);
        check({t, "_busy"}, busy, 0);
        check({t, "_err"}, rd_timeout_err, 0);
    endtask

    task automatic reset_model();
        fifo0.delete();
        fifo1.delete();
        pres    = '0;
        phase   = 0;
        m_last  = 1;
        exp_vld = '0;
        exp_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int eo[$];
        for (int r = 0; r < 2; r++) begin
            rq_addr[r] = '0; rq_be[r] = '0; rq_wdata[r] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset("por");

        // Single write from requester 0, no downstream wait
        fifo0.push_back(mk(1'b0, 1'b1, 17'h00208, 4'hF, 32'h0000_0003));
        run_until_idle("wr0", 20);

        // Contention under fixed priority
        order.delete();
        fifo0.push_back(mk(1'b0, 1'b1, 17'h00100, 4'hF, 32'h1111_0000));
        fifo1.push_back(mk(1'b0, 1'b1, 17'h10100, 4'h3, 32'h2222_0000));
        run_until_idle("fixprio", 40);
        eo = '{0, 1};
        check_order("fixprio_order", eo);

        // Contention after calibration: strict alternation
        calib_done = 1'b1;
        order.delete();
        for (int i = 0; i < 4; i++) begin
            fifo0.push_back(mk(1'b0, 1'b1, 17'h00110 + 17'(i), 4'hF, 32'hA000_0000 + i));
            fifo1.push_back(mk(1'b0, 1'b1, 17'h10110 + 17'(i), 4'hC, 32'hB000_0000 + i));
        end
        run_until_idle("rr", 80);
        eo = '{0, 1, 0, 1, 0, 1, 0, 1};
        check_order("rr_order", eo);

        // Read from requester 1 with bridge stalls and delayed data
        br_stall = 3;
        br_dly   = 5;
        br_data  = 32'hA5A5_1234;
        fifo1.push_back(mk(1'b1, 1'b0, 17'h00300, 4'hF, 32'h0));
        run_until_idle("rd_stall", 40);
        check("rd_stall_rdata1", rq1_rdata, 32'hA5A5_1234);

        // Read that never returns, followed by late readdatavalid
        br_stall  = 0;
        br_noresp = 1'b1;
        fifo0.push_back(mk(1'b1, 1'b0, 17'h00400, 4'hF, 32'h0));
        run_until_idle("tmo", TMO + 20);
        stray_pct = 100;
        run_cycles(4);
        stray_pct = 0;
        br_noresp = 1'b0;

        // Randomized traffic with changing calib_done and stray readdatavalid
        br_rand    = 1'b1;
        calib_rand = 1'b1;
        gap_pct    = 30;
        stray_pct  = 10;
        for (int i = 0; i < 80; i++) begin
            int k;
            k = int'($urandom_range(0, 3));
            if (i % 2 == 0)
                fifo0.push_back(mk(k == 0 || k == 3, k != 0, ADW'($urandom), BW'($urandom), $urandom));
            else
                fifo1.push_back(mk(k == 0 || k == 3, k != 0, ADW'($urandom), BW'($urandom), $urandom));
        end
        run_until_idle("rand", 20000);
        br_rand    = 1'b0;
        calib_rand = 1'b0;
        gap_pct    = 0;
        stray_pct  = 0;

        // Reset while a command is stalled on the bus
        br_stall = 1000;
        fifo0.push_back(mk(1'b0, 1'b1, 17'h00500, 4'hF, 32'hDEAD_BEEF));
        run_cycles(4);
        check("rst_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        rq_read  = '0;
        rq_write = '0;
        reset_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        br_stall = 0;
        fifo0.push_back(mk(1'b0, 1'b1, 17'h00208, 4'hF, 32'h0000_0003));
        run_until_idle("post_rst_wr", 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_aib_avmm_cfg_arbiter
`default_nettype wire
